regbank_arbiter: RTL and testbench

//  Two-port round-robin arbiter that owns the I2C target's NUM_REGS x DATA_W register bank.
//  The bank is shared between the I2C-side byte engine and a local host port.

---
 rtl/regbank_pkg.sv | 18 +
 rtl/regbank_if.sv | 17 +
 rtl/regbank_rr_pick.sv | 23 ++
 rtl/regbank_arbiter.sv | 159 +++++++++++++++
 tb/tb_regbank_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// Shared types for the I2C register-bank arbiter: FSM states, requester IDs
// and the position of the LOCK bit inside the lock register.
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I2C  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

    localparam int LOCK_BIT = 0;

endpackage

// File: rtl/regbank_if.sv
// Single-word req/ack access port into the register bank.
// master = requester (I2C byte engine or host), slave = the arbiter.
interface regbank_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/regbank_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; under contention the
// requester that did not receive the previous grant wins.
module regbank_rr_pick
    import regbank_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       valid,
    output req_id_t    winner
);

    // Winner selection, indexed by req_id_t (bit0 = I2C, bit1 = host)
    always_comb begin
        valid  = |req;
        winner = REQ_I2C;
        if (req[REQ_I2C] && req[REQ_HOST]) begin
            winner = (last_grant == REQ_I2C) ? REQ_HOST : REQ_I2C;
        end else if (req[REQ_HOST]) begin
            winner = REQ_HOST;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter owning the I2C target's NUM_REGS x DATA_W register bank,
// shared between the I2C byte engine and a local host port. One access in
// flight at a time: IDLE (grant + command latch) -> ACCESS -> RESP (ack).
// Optional build macro REGBANK_WPROT_EN: the last register is a lock register
// whose LOCK bit makes the bank read-only for host writes (except to itself).
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
)(
    input  logic     clock,
    input  logic     reset,
    regbank_if.slave i2c,
    regbank_if.slave host
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    arb_state_t        state_q, state_d;
    req_id_t           last_grant_q, last_grant_d;
    req_id_t           cmd_id_q, cmd_id_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              i2c_ack_q, i2c_ack_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              pick_valid;
    req_id_t           pick_id;
    logic              addr_ok;
    logic [DATA_W-1:0] rd_word;

    regbank_rr_pick u_pick (
        .req        ({host.req, i2c.req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    // Out-of-range indices discard writes and read back as zero
    assign addr_ok = (int'(cmd_addr_q) < NUM_REGS);
    assign rd_word = addr_ok ? regs_q[cmd_addr_q] : '0;

`ifdef REGBANK_WPROT_EN
    logic wr_blocked;
    logic host_err_q, host_err_d;

    assign wr_blocked = (cmd_id_q == REQ_HOST) && cmd_we_q
                        && regs_q[NUM_REGS-1][LOCK_BIT]
                        && (int'(cmd_addr_q) < NUM_REGS-1);

    // Error flag rides alongside host_ack when LOCK discarded the write
    always_comb begin
        host_err_d = (state_q == ACCESS) && wr_blocked;
    end

    // Error flag register
    always_ff @(posedge clock) begin
        if (reset) host_err_q <= 1'b0;
        else       host_err_q <= host_err_d;
    end

    assign host.err = host_err_q;
`else
    logic wr_blocked;
    assign wr_blocked = 1'b0;
    assign host.err   = 1'b0;
`endif

    // FSM, command latch, bank update and per-port response staging
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_id_d     = cmd_id_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        i2c_rdata_d  = i2c_rdata_q;
        host_rdata_d = host_rdata_q;
        i2c_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        regs_d       = regs_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cmd_id_d = pick_id;
                    if (pick_id == REQ_I2C) begin
                        cmd_we_d    = i2c.we;
                        cmd_addr_d  = i2c.addr;
                        cmd_wdata_d = i2c.wdata;
                    end else begin
                        cmd_we_d    = host.we;
                        cmd_addr_d  = host.addr;
                        cmd_wdata_d = host.wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_we_q) begin
                    if (addr_ok && !wr_blocked) regs_d[cmd_addr_q] = cmd_wdata_q;
                end else if (cmd_id_q == REQ_I2C) begin
                    i2c_rdata_d = rd_word;
                end else begin
                    host_rdata_d = rd_word;
                end
                if (cmd_id_q == REQ_I2C) i2c_ack_d  = 1'b1;
                else                     host_ack_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                last_grant_d = cmd_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight access
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_HOST;
            cmd_id_q     <= REQ_I2C;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
            i2c_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_id_q     <= cmd_id_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            i2c_rdata_q  <= i2c_rdata_d;
            host_rdata_q <= host_rdata_d;
            i2c_ack_q    <= i2c_ack_d;
            host_ack_q   <= host_ack_d;
            regs_q       <= regs_d;
        end
    end

    assign i2c.ack    = i2c_ack_q;
    assign i2c.rdata  = i2c_rdata_q;
    assign i2c.err    = 1'b0;
    assign host.ack   = host_ack_q;
    assign host.rdata = host_rdata_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: expected acks (requester, cycle, read
// data, error flag) are queued as stimulus is issued and consumed by a monitor
// that samples on the falling clock edge.
module tb_regbank_arbiter;

`ifdef REGBANK_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    typedef struct {
        bit         id;     // 0 = I2C, 1 = host
        bit         rd;
        logic [7:0] data;
        bit         err;
        int         at;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   i2c_acks  = 0;
    int   host_acks = 0;
    bit   stray_err = 1'b0;
    exp_t sb[$];

    regbank_if #(.ADDR_W(3), .DATA_W(8)) i2c_bus ();
    regbank_if #(.ADDR_W(3), .DATA_W(8)) host_bus ();

    regbank_arbiter #(.NUM_REGS(8), .DATA_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .i2c   (i2c_bus),
        .host  (host_bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void expect_ack(input bit id, input bit rd, input logic [7:0] data,
                                       input bit err, input int at);
        exp_t e;
        e.id = id; e.rd = rd; e.data = data; e.err = err; e.at = at;
        sb.push_back(e);
    endfunction

    task automatic drive(input bit id, input bit req, input bit we,
                         input logic [2:0] a, input logic [7:0] d);
        if (id) begin
            host_bus.req = req; host_bus.we = we; host_bus.addr = a; host_bus.wdata = d;
        end else begin
            i2c_bus.req = req; i2c_bus.we = we; i2c_bus.addr = a; i2c_bus.wdata = d;
        end
    endtask

    // Raise req and keep it up for n accesses; write data steps by one per access
    task automatic run_port(input bit id, input bit we, input logic [2:0] a,
                            input logic [7:0] wd0, input int n);
        bit got;
        logic [7:0] wd;
        wd = wd0;
        drive(id, 1'b1, we, a, wd);
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clock);
                got = id ? host_bus.ack : i2c_bus.ack;
            end
            check(id ? "host_ack_arrived" : "i2c_ack_arrived", 32'(got), 32'd1);
            if (k == n - 1 || !got) begin
                drive(id, 1'b0, we, a, wd);
                break;
            end
            wd = wd + 8'd1;
            drive(id, 1'b1, we, a, wd);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(negedge clock);
        check({tag, "_i2c_ack"},   32'(i2c_bus.ack),    32'd0);
        check({tag, "_host_ack"},  32'(host_bus.ack),   32'd0);
        check({tag, "_host_err"},  32'(host_bus.err),   32'd0);
        check({tag, "_i2c_rdata"}, 32'(i2c_bus.rdata),  32'd0);
        check({tag, "_host_rdata"},32'(host_bus.rdata), 32'd0);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Ack monitor: pops one expectation per ack and compares against it
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (i2c_bus.err || (host_bus.err && !host_bus.ack)) stray_err = 1'b1;
            if (i2c_bus.ack)  i2c_acks++;
            if (host_bus.ack) host_acks++;
            if (i2c_bus.ack || host_bus.ack) begin
                check("single_ack", 32'(i2c_bus.ack & host_bus.ack), 32'd0);
                check("ack_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("grant_order", 32'(host_bus.ack), 32'(e.id));
                    check("ack_cycle", 32'(cyc), 32'(e.at));
                    if (e.rd)
                        check(e.id ? "host_rdata" : "i2c_rdata",
                              32'(e.id ? host_bus.rdata : i2c_bus.rdata), 32'(e.data));
                    check("host_err", 32'(host_bus.err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int a0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

        // Reset state, then single I2C write and read-back of addr 3
        do_reset("reset");
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, cyc + 2);
        run_port(1'b0, 1'b1, 3'd3, 8'hA5, 1);
        @(negedge clock);
        expect_ack(1'b0, 1'b1, 8'hA5, 1'b0, cyc + 2);
        run_port(1'b0, 1'b0, 3'd3, 8'h00, 1);
        @(negedge clock);

        // Contention from reset: I2C first, host second, host data survives
        do_reset("reset2");
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, cyc + 2);
        expect_ack(1'b1, 1'b0, 8'h00, 1'b0, cyc + 5);
        fork
            run_port(1'b0, 1'b1, 3'd5, 8'h22, 1);
            run_port(1'b1, 1'b1, 3'd5, 8'h11, 1);
        join
        @(negedge clock);
        expect_ack(1'b0, 1'b1, 8'h11, 1'b0, cyc + 2);
        run_port(1'b0, 1'b0, 3'd5, 8'h00, 1);
        @(negedge clock);

        // Both hold req for six accesses: I2C writes addr 6, host reads it back
        do_reset("reset3");
        a0 = cyc;
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, a0 + 2);
        expect_ack(1'b1, 1'b1, 8'h31, 1'b0, a0 + 5);
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, a0 + 8);
        expect_ack(1'b1, 1'b1, 8'h32, 1'b0, a0 + 11);
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, a0 + 14);
        expect_ack(1'b1, 1'b1, 8'h33, 1'b0, a0 + 17);
        fork
            run_port(1'b0, 1'b1, 3'd6, 8'h31, 3);
            run_port(1'b1, 1'b0, 3'd6, 8'h00, 3);
        join
        @(negedge clock);

        // Host read with req dropped during ACCESS: one ack, no repeat
        a0 = host_acks;
        expect_ack(1'b1, 1'b1, 8'h33, 1'b0, cyc + 2);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 3'd6, 8'h00);
        repeat (8) @(negedge clock);
        check("drop_req_ack_count", 32'(host_acks - a0), 32'd1);

        // Reset during ACCESS of an I2C write: abandoned, no ack, bank cleared
        a0 = i2c_acks;
        drive(1'b0, 1'b1, 1'b1, 3'd2, 8'hFF);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 3'd2, 8'hFF);
        repeat (2) @(negedge clock);
        check("rst_mid_host_rdata", 32'(host_bus.rdata), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_mid_no_ack", 32'(i2c_acks - a0), 32'd0);
        expect_ack(1'b0, 1'b1, 8'h00, 1'b0, cyc + 2);
        run_port(1'b0, 1'b0, 3'd2, 8'h00, 1);
        @(negedge clock);

        // Lock register: host blocked (with err) only when protection is built in
        expect_ack(1'b1, 1'b0, 8'h00, 1'b0, cyc + 2);
        run_port(1'b1, 1'b1, 3'd7, 8'h01, 1);
        @(negedge clock);
        expect_ack(1'b1, 1'b0, 8'h00, WPROT, cyc + 2);
        run_port(1'b1, 1'b1, 3'd0, 8'h55, 1);
        @(negedge clock);
        expect_ack(1'b1, 1'b1, WPROT ? 8'h00 : 8'h55, 1'b0, cyc + 2);
        run_port(1'b1, 1'b0, 3'd0, 8'h00, 1);
        @(negedge clock);
        expect_ack(1'b0, 1'b0, 8'h00, 1'b0, cyc + 2);
        run_port(1'b0, 1'b1, 3'd0, 8'h66, 1);
        @(negedge clock);
        expect_ack(1'b0, 1'b1, 8'h66, 1'b0, cyc + 2);
        run_port(1'b0, 1'b0, 3'd0, 8'h00, 1);
        @(negedge clock);
        expect_ack(1'b1, 1'b0, 8'h00, 1'b0, cyc + 2);
        run_port(1'b1, 1'b1, 3'd7, 8'h00, 1);
        @(negedge clock);
        expect_ack(1'b1, 1'b0, 8'h00, 1'b0, cyc + 2);
        run_port(1'b1, 1'b1, 3'd0, 8'h77, 1);
        @(negedge clock);
        expect_ack(1'b0, 1'b1, 8'h77, 1'b0, cyc + 2);
        run_port(1'b0, 1'b0, 3'd0, 8'h00, 1);

        repeat (6) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("no_stray_err", 32'(stray_err), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
